// File: rtl/down_counter.sv
// ============================================================================
// down_counter : free-running down-counter with tc/wrap status; optional
//                DOWNCOUNTER_SATURATE_EN holds at zero instead of reloading.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module down_counter #(
  parameter int WIDTH      = 4,
  parameter int MAX_VALUE  = (2 ** WIDTH) - 1,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [WIDTH-1:0]      counter,
  output logic                  tc,
  output logic                  wrap,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0] C_RELOAD = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0]      counter_q, counter_d;
  logic                  wrap_q, wrap_d;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic                  w_zero;

  assign w_zero = (counter_q == '0);

  always_comb begin
    counter_d  = counter_q;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    if (!w_zero) begin
      counter_d = counter_q - 1'b1;
    end else begin
`ifdef DOWNCOUNTER_SATURATE_EN
      counter_d = '0;
`else
      counter_d = C_RELOAD;
      wrap_d    = 1'b1;
      // Event counter sticks at all-ones; wrap pulses keep coming regardless.
      if (wrap_cnt_q != '1) begin
        wrap_cnt_d = wrap_cnt_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q  <= C_RELOAD;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      counter_q  <= counter_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign counter  = counter_q;
  assign tc       = w_zero;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_down_counter.sv
// ============================================================================
// tb_down_counter : directed scoreboard bench for down_counter (both builds).
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_down_counter;

  localparam int WIDTH = 4;
  localparam int MAXV  = 15;
  localparam int WCW   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] counter;
  logic             tc;
  logic             wrap;
  logic [WCW-1:0]   wrap_cnt;

  always #5 clk = ~clk;

  down_counter #(
    .WIDTH      (WIDTH),
    .MAX_VALUE  (MAXV),
    .WRAP_CNT_W (WCW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .counter  (counter),
    .tc       (tc),
    .wrap     (wrap),
    .wrap_cnt (wrap_cnt)
  );

  typedef struct packed {
    logic [WIDTH-1:0] c;
    logic             tc;
    logic             wrap;
    logic [WCW-1:0]   wc;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int m_cnt    = 0;
  bit m_wrap   = 1'b0;
  int m_wc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the reference model one edge, queue its prediction, then compare.
  task automatic step(input bit rst, input string tag);
    exp_t e;
    reset = rst;
    if (rst) begin
      m_cnt = MAXV; m_wrap = 1'b0; m_wc = 0;
    end else if (m_cnt != 0) begin
      m_cnt = m_cnt - 1; m_wrap = 1'b0;
    end else begin
`ifdef DOWNCOUNTER_SATURATE_EN
      m_wrap = 1'b0;
`else
      m_cnt  = MAXV;
      m_wrap = 1'b1;
      if (m_wc != (1 << WCW) - 1) m_wc = m_wc + 1;
`endif
    end
    e.c    = m_cnt[WIDTH-1:0];
    e.tc   = (m_cnt == 0);
    e.wrap = m_wrap;
    e.wc   = m_wc[WCW-1:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".counter"},  32'(counter),  32'(e.c));
    check({tag, ".tc"},       32'(tc),       32'(e.tc));
    check({tag, ".wrap"},     32'(wrap),     32'(e.wrap));
    check({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(e.wc));
  endtask

  initial begin
    int wraps;
    int tcs;
    int last_tc;
    reset = 1'b1;

    step(1'b1, "rst_a");
    step(1'b1, "rst_b");
    check("reset_hold.counter", 32'(counter), 32'(MAXV));
    check("reset_hold.tc", 32'(tc), 32'd0);

    step(1'b0, "rel1");
    check("first_decrement", 32'(counter), 32'd14);
    step(1'b0, "rel2");
    check("second_decrement", 32'(counter), 32'd13);
    for (int i = 0; i < 13; i++) step(1'b0, "count_down");
    check("edge15.counter", 32'(counter), 32'd0);
    check("edge15.tc", 32'(tc), 32'd1);

    step(1'b0, "edge16");
`ifdef DOWNCOUNTER_SATURATE_EN
    for (int i = 0; i < 4; i++) step(1'b0, "sat_hold");
    check("sat_edge20.counter", 32'(counter), 32'd0);
    check("sat_edge20.tc", 32'(tc), 32'd1);
`else
    check("reload.counter", 32'(counter), 32'(MAXV));
    check("reload.wrap", 32'(wrap), 32'd1);
    check("reload.wrap_cnt", 32'(wrap_cnt), 32'd1);
`endif

    wraps = 0; tcs = 0; last_tc = -1;
    for (int i = 0; i < 48; i++) begin
      step(1'b0, "free_run");
      if (wrap) wraps++;
      if (tc) begin
        tcs++;
`ifndef DOWNCOUNTER_SATURATE_EN
        if (last_tc >= 0) check("tc_spacing", 32'(i - last_tc), 32'd16);
`endif
        last_tc = i;
      end
    end
`ifdef DOWNCOUNTER_SATURATE_EN
    check("free_run.wrap_pulses", 32'(wraps), 32'd0);
    check("free_run.tc_cycles", 32'(tcs), 32'd48);
`else
    check("free_run.wrap_pulses", 32'(wraps), 32'd3);
    check("free_run.tc_cycles", 32'(tcs), 32'd3);
`endif

    step(1'b1, "restart");
    while (m_cnt != 6) step(1'b0, "to_six");
    check("at_six", 32'(counter), 32'd6);
    step(1'b1, "mid_reset");
    check("mid_reset.counter", 32'(counter), 32'(MAXV));
    check("mid_reset.wrap_cnt", 32'(wrap_cnt), 32'd0);
    step(1'b0, "resume");
    check("resume.counter", 32'(counter), 32'd14);

    while (m_cnt != 0) step(1'b0, "to_zero");
    check("pre_coincident.tc", 32'(tc), 32'd1);
    step(1'b1, "coincident_reset");
    check("coincident.counter", 32'(counter), 32'(MAXV));
    check("coincident.wrap", 32'(wrap), 32'd0);
    check("coincident.wrap_cnt", 32'(wrap_cnt), 32'd0);

    // 260 periods drive wrap_cnt past all-ones; wraps must continue after.
    wraps = 0;
    for (int i = 0; i < 260 * 16; i++) begin
      step(1'b0, "saturate");
      if (wrap) wraps++;
    end
`ifdef DOWNCOUNTER_SATURATE_EN
    check("wrap_cnt_sat.value", 32'(wrap_cnt), 32'd0);
    check("wrap_cnt_sat.pulses", 32'(wraps), 32'd0);
`else
    check("wrap_cnt_sat.value", 32'(wrap_cnt), 32'd255);
    check("wrap_cnt_sat.pulses", 32'(wraps), 32'd260);
`endif
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
